pll_lock_monitor: RTL

//  Digital lock detector for the avsdpll-to-RVMyth interface, running on the PLL output clock.

---
 rtl/pll_mon_pkg.sv | 26 ++
 rtl/pll_ref_edge_sync.sv | 24 ++
 rtl/pll_lock_monitor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor.
//  - pll_state_e : monitor FSM states
//  - exp_lo/exp_hi : acceptance bounds of a window count, MULT*REF_CYCLES -/+ TOL
//  - is_lock_state : states in which the lock output is asserted
package pll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } pll_state_e;

  function automatic int exp_lo(input int mult, input int ref_cycles, input int tol);
    return mult * ref_cycles - tol;
  endfunction

  function automatic int exp_hi(input int mult, input int ref_cycles, input int tol);
    return mult * ref_cycles + tol;
  endfunction

  function automatic logic is_lock_state(input pll_state_e s);
    return (s == LOCKED) || (s == HOLD);
  endfunction

endpackage

// File: rtl/pll_ref_edge_sync.sv
// REF synchroniser: two metastability flops plus one delay flop for
// rising-edge detection on the synchronised signal.
//  clk      in  PLL output clock
//  reset    in  synchronous, active-high; clears every flop
//  ref_in   in  REF clock, asynchronous to clk
//  ref_rise out one-cycle pulse per synchronised REF rising edge
module pll_ref_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ref_in,
  output logic ref_rise
);

  // sh[0]: first sync stage, sh[1]: synchronised REF, sh[2]: previous sample
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], ref_in};
  end

  assign ref_rise = sh[1] & ~sh[2];

endmodule

// File: rtl/pll_lock_monitor.sv
// Digital lock detector for the avsdpll -> RVMyth interface, clocked by the
// PLL output. Counts clk cycles across REF_CYCLES REF periods, compares the
// count with MULT*REF_CYCLES +/- TOL, declares lock after LOCK_WINDOWS good
// windows in a row and drops it after UNLOCK_WINDOWS bad ones. The RVMyth
// core is held in reset until RST_RELEASE cycles after lock rises. A REF
// silence of REF_TIMEOUT cycles raises the sticky ref_lost flag.
//
// Optional feature: define PLL_MON_LOL_CNT_EN to build the loss-of-lock
// event counter; otherwise lol_count is tied to zero.
//
// Ports:
//  clk        in   PLL output clock (only clock)
//  reset      in   synchronous reset, active-high
//  en         in   monitor enable (EN_VCO)
//  ref_in     in   REF clock, asynchronous
//  lock       out  PLL locked
//  core_reset out  RVMyth reset, active-high
//  meas_count out  clk count of the last completed window
//  meas_valid out  one-cycle pulse when meas_count updates
//  ref_lost   out  sticky REF-timeout flag, cleared by reset or en low
//  lol_count  out  saturating count of lock-loss events
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int MULT           = 8,
  parameter int REF_CYCLES     = 16,
  parameter int TOL            = 2,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int REF_TIMEOUT    = 1024,
  parameter int RST_RELEASE    = 16,
  parameter int COUNT_W        = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               ref_in,
  output logic               lock,
  output logic               core_reset,
  output logic [COUNT_W-1:0] meas_count,
  output logic               meas_valid,
  output logic               ref_lost,
  output logic [7:0]         lol_count
);

  localparam logic [COUNT_W-1:0] LO      = COUNT_W'(exp_lo(MULT, REF_CYCLES, TOL));
  localparam logic [COUNT_W-1:0] HI      = COUNT_W'(exp_hi(MULT, REF_CYCLES, TOL));
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam int EW = $clog2(REF_CYCLES + 1);
  localparam int TW = $clog2(REF_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int BW = $clog2(UNLOCK_WINDOWS + 1);
  localparam int RW = $clog2(RST_RELEASE + 1);

  pll_state_e       state, state_nxt;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic [BW-1:0]    bad_cnt, bad_nxt;
  logic [RW-1:0]    rel_cnt, rel_nxt;
  logic             lock_nxt;
  logic             win_open;
  logic [COUNT_W-1:0] cnt, cnt_inc;
  logic [EW-1:0]    ecnt;
  logic [TW-1:0]    tcnt, tcnt_inc;
  logic             ref_rise, close_win, win_good, timeout;

  pll_ref_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ref_in   (ref_in),
    .ref_rise (ref_rise)
  );

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + COUNT_W'(1);
  // tcnt holds clk cycles since the last REF edge; timeout fires on the
  // cycle it reaches REF_TIMEOUT, and an edge in that cycle wins.
  assign tcnt_inc = (tcnt == TW'(REF_TIMEOUT)) ? tcnt : tcnt + TW'(1);
  assign timeout  = !ref_rise && (tcnt_inc == TW'(REF_TIMEOUT));
  assign close_win = ref_rise && win_open && (ecnt == EW'(REF_CYCLES - 1));
  assign win_good  = (cnt >= LO) && (cnt <= HI) && (cnt != CNT_MAX);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (!en) begin
      state_nxt = IDLE;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (state == IDLE) begin
      state_nxt = ACQUIRE;
    end else if (timeout) begin
      state_nxt = ACQUIRE;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (close_win) begin
      if (state == ACQUIRE) begin
        if (!win_good)
          good_nxt = '0;
        else if (good_cnt == GW'(LOCK_WINDOWS - 1)) begin
          state_nxt = LOCKED;
          good_nxt  = '0;
        end else
          good_nxt = good_cnt + GW'(1);
      end else begin
        // LOCKED and HOLD share this path: bad_cnt is zero in LOCKED
        if (win_good) begin
          state_nxt = LOCKED;
          bad_nxt   = '0;
        end else if (bad_cnt == BW'(UNLOCK_WINDOWS - 1)) begin
          state_nxt = ACQUIRE;
          bad_nxt   = '0;
        end else begin
          state_nxt = HOLD;
          bad_nxt   = bad_cnt + BW'(1);
        end
      end
    end
  end

  assign lock_nxt = is_lock_state(state_nxt);

  // Release counter runs only while lock is already high, so core_reset
  // drops exactly RST_RELEASE cycles after lock rises.
  always_comb begin
    rel_nxt = '0;
    if (lock_nxt)
      rel_nxt = (lock && rel_cnt != RW'(RST_RELEASE)) ? rel_cnt + RW'(1) : rel_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      lock       <= 1'b0;
      rel_cnt    <= '0;
      core_reset <= 1'b1;
      win_open   <= 1'b0;
      cnt        <= '0;
      ecnt       <= '0;
      tcnt       <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      ref_lost   <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      lock       <= lock_nxt;
      rel_cnt    <= rel_nxt;
      core_reset <= !(lock_nxt && rel_nxt == RW'(RST_RELEASE));
      meas_valid <= 1'b0;
      if (!en || state == IDLE) begin
        win_open   <= 1'b0;
        cnt        <= '0;
        ecnt       <= '0;
        tcnt       <= '0;
        meas_count <= '0;
        ref_lost   <= 1'b0;
      end else if (timeout) begin
        ref_lost <= 1'b1;
        win_open <= 1'b0;  // partial window is discarded
        tcnt     <= tcnt_inc;
        cnt      <= '0;
        ecnt     <= '0;
      end else begin
        tcnt <= ref_rise ? TW'(1) : tcnt_inc;
        cnt  <= cnt_inc;
        if (ref_rise) begin
          if (!win_open) begin
            // opening edge: start counting, nothing to report
            win_open <= 1'b1;
            cnt      <= COUNT_W'(1);
            ecnt     <= '0;
          end else if (close_win) begin
            // windows are back to back: the closing edge opens the next one
            meas_count <= cnt;
            meas_valid <= 1'b1;
            cnt        <= COUNT_W'(1);
            ecnt       <= '0;
          end else begin
            ecnt <= ecnt + EW'(1);
          end
        end
      end
    end
  end

`ifdef PLL_MON_LOL_CNT_EN
  logic [7:0] lol_q;
  logic       lol_evt;

  // only lock-loss into ACQUIRE counts; en low forces IDLE and is excluded
  assign lol_evt = en && is_lock_state(state) && (state_nxt == ACQUIRE);

  always_ff @(posedge clk) begin
    if (reset)                         lol_q <= '0;
    else if (lol_evt && lol_q != 8'hFF) lol_q <= lol_q + 8'd1;
  end

  assign lol_count = lol_q;
`else
  assign lol_count = 8'd0;
`endif

endmodule
